wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Integer register file that receives Stage 3 writeback traffic (write enable, destination, writeback data, CSR write enable) and serves the two Stage 1 operand read ports.
- Provides same-cycle write-to-read bypass so Stage 1 sees the value Stage 3 is committing this cycle.
- Holds the tohost CSR and a retired-write counter used by the bench for completion detection.

Parameters:
DWIDTH, 32, data width of registers and CSR
AWIDTH, 5, register address width (2^AWIDTH entries, entry 0 hardwired)
BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled, 0 = read returns stored value only
TOHOST_ADDR, 12'h51E, CSR address accepted by the CSR write port

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
we  input  1  register write enable (rwe from Stage 3)
waddr  input  AWIDTH  destination register (inst[11:7] of writeback instruction)
wdata  input  DWIDTH  writeback data (wb_data from Stage 3)
ra1  input  AWIDTH  read address port 1 (rs1)
ra2  input  AWIDTH  read address port 2 (rs2)
rd1  output  DWIDTH  read data port 1
rd2  output  DWIDTH  read data port 2
csr_we  input  1  CSR write enable (csr_we from Stage 3)
csr_addr  input  12  CSR address (inst[31:20])
csr_wdata  input  DWIDTH  CSR write data
tohost  output  DWIDTH  current tohost CSR value
wr_count  output  32  number of committed register writes since reset

Behaviour:
- Reset: asynchronous on reset_n low. All entries 1..31 clear to 0, tohost clears to 0, and wr_count clears to 0. rd1/rd2 read 0 while in reset. Deassertion is sampled synchronously: the first write can commit on the first rising edge with reset_n high.
- Write: on rising clk with we=1 and waddr!=0, mem[waddr] <= wdata, committed in the same cycle (1-cycle write latency). A write with waddr=0 is discarded.
- Read: rd1/rd2 are combinational, with zero-cycle latency.
  - If raN==0, rdN=0 regardless of any write.
  - Else if BYPASS=1, we=1 and waddr==raN, rdN=wdata (forwarded this cycle).
  - Else rdN=mem[raN].
- Both ports may address the same register. Both forward independently and identically.
- wr_count increments by 1 on each edge where we=1 and waddr!=0. It wraps from 32'hFFFFFFFF to 0 with no saturation or flag.
- CSR: on rising clk with csr_we=1 and csr_addr==TOHOST_ADDR, tohost <= csr_wdata. Other addresses are ignored with no side effect.
- csr_we and we asserted in the same cycle: both commit independently. CSR writes do not affect wr_count. We/waddr and csr port are unrelated.
- X-safety: when we=0, waddr/wdata are don't-care and must not alter state or rd outputs. When csr_we=0, csr_addr/csr_wdata are don't-care.
- Reset mid-operation: a write in the cycle reset_n falls is lost. Reset wins over any simultaneous write.
- No handshake or backpressure. Stage 3 presents one writeback per cycle and this block always accepts it.

Test Plan:
- Reset values: hold reset_n=0, then release. Read all 32 addresses -> rd1=rd2=0, tohost=0, wr_count=0.
- Basic write/read: we=1, waddr=5, wdata=32'hDEADBEEF for one cycle, then ra1=5 -> rd1=32'hDEADBEEF next cycle; wr_count=1.
- Bypass: we=1, waddr=7, wdata=32'h12345678 with ra1=ra2=7 in the same cycle -> rd1=rd2=32'h12345678 before the edge. Repeat with BYPASS=0 -> old value (0) before the edge, 32'h12345678 after.
- x0 protection: we=1, waddr=0, wdata=32'hFFFFFFFF, ra1=0 -> rd1=0 in the same and next cycle; wr_count unchanged.
- CSR: csr_we=1, csr_addr=12'h51E, csr_wdata=1 -> tohost=1 after the edge. csr_addr=12'h300, csr_wdata=5 -> tohost stays 1. Simultaneous we to x3 with csr_we -> both commit and wr_count increments by 1.
- Async reset mid-stream: after writes to x1..x4, pulse reset_n low between edges -> all reads 0 and wr_count=0 immediately, without a clock edge. A write pending at the falling edge is not committed.

Source files
------------

// File: rtl/wb_regfile.sv
// Integer register file fed by Stage 3 writeback, serving the two Stage 1 operand ports,
// plus the tohost CSR and a count of committed register writes.
module wb_regfile #(
  parameter int          DWIDTH      = 32,
  parameter int          AWIDTH      = 5,
  parameter bit          BYPASS      = 1'b1,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  input  logic              csr_we,
  input  logic [11:0]       csr_addr,
  input  logic [DWIDTH-1:0] csr_wdata,
  output logic [DWIDTH-1:0] tohost,
  output logic [31:0]       wr_count
);
  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0][DWIDTH-1:0] mem_q, mem_d;
  logic [DWIDTH-1:0]           tohost_q, tohost_d;
  logic [31:0]                 wr_count_q, wr_count_d;
  logic                        wr_en, csr_en;

  // Gating with reset_n keeps the bypass path quiet while reset is held.
  assign wr_en  = reset_n && we && (waddr != '0);
  assign csr_en = csr_we && (csr_addr == TOHOST_ADDR);

  always_comb begin
    mem_d      = mem_q;
    tohost_d   = tohost_q;
    wr_count_d = wr_count_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
      wr_count_d   = wr_count_q + 32'd1;
    end
    mem_d[0] = '0;
    if (csr_en) tohost_d = csr_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      tohost_q   <= '0;
      wr_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      tohost_q   <= tohost_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    if (ra1 == '0)                          rd1 = '0;
    else if (BYPASS && wr_en && waddr == ra1) rd1 = wdata;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (ra2 == '0)                          rd2 = '0;
    else if (BYPASS && wr_en && waddr == ra2) rd2 = wdata;
  end

  assign tohost   = tohost_q;
  assign wr_count = wr_count_q;
endmodule
